// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings, stream
// framing constants and the per-state status decode.
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing 8-bit checksum byte.
package imem_loader_pkg;

    localparam int unsigned HdrBytes     = 2;
    localparam int unsigned BytesPerWord = 4;
    localparam int unsigned ByteCntW     = 2;

    localparam logic [ByteCntW-1:0] HdrLast  = ByteCntW'(HdrBytes - 1);
    localparam logic [ByteCntW-1:0] WordLast = ByteCntW'(BytesPerWord - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHdr   = 3'd1,
        StData  = 3'd2,
        StCksum = 3'd3,
        StDone  = 3'd4,
        StErr   = 3'd5
    } state_e;

    // State entered once the last word (or an empty header) has been consumed.
    localparam state_e StTail = StCksum;
`else
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHdr   = 3'd1,
        StData  = 3'd2,
        StDone  = 3'd4,
        StErr   = 3'd5
    } state_e;

    localparam state_e StTail = StDone;
`endif

    typedef struct packed {
        logic rx_ready;
        logic busy;
        logic done;
        logic error;
        logic core_reset;
    } status_t;

    // Status flags that belong to each state; registered alongside the state.
    function automatic status_t status_of(state_e s);
        status_t st;
        st = '{rx_ready: 1'b0, busy: 1'b0, done: 1'b0, error: 1'b0, core_reset: 1'b1};
        case (s)
            StHdr, StData: begin
                st.rx_ready = 1'b1;
                st.busy     = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCksum: begin
                st.rx_ready = 1'b1;
                st.busy     = 1'b1;
            end
`endif
            StDone: begin
                st.done       = 1'b1;
                st.core_reset = 1'b0;
            end
            StErr: begin
                st.error = 1'b1;
            end
            default: begin
            end
        endcase
        return st;
    endfunction

endpackage

// File: rtl/imem_loader_pack.sv
// Byte counter and little-endian byte-to-word shift register. The first byte
// of a word lands in bits 7:0; a completed word is presented with a one-cycle
// word_valid_o in the cycle after its fourth byte is accepted.
module imem_loader_pack
    import imem_loader_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                byte_en_i,
    input  logic [7:0]          byte_i,
    output logic                word_valid_o,
    output logic [31:0]         word_o,
    output logic [ByteCntW-1:0] byte_cnt_o,
    output logic [7:0]          hdr_lo_o
);

    logic [ByteCntW-1:0] cnt_q, cnt_d;
    logic [31:0]         shreg_q, shreg_d;
    logic [31:0]         word_q, word_d;
    logic                word_valid_q, word_valid_d;

    // Shift in accepted bytes; clear wins over a same-cycle byte.
    always_comb begin
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear_i) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (byte_en_i) begin
            shreg_d = {byte_i, shreg_q[31:8]};
            cnt_d   = cnt_q + ByteCntW'(1);
            if (cnt_q == WordLast) begin
                word_d       = {byte_i, shreg_q[31:8]};
                word_valid_d = 1'b1;
            end
        end
    end

    // Pack state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            shreg_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;
    assign byte_cnt_o   = cnt_q;
    // After one header byte the shift register holds it in the top lane.
    assign hdr_lo_o     = shreg_q[31:24];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed little-endian byte
// stream, writes it word by word into instruction memory and holds the core
// in reset until a load completes.
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned MaxWords = 1 << ADDR_WIDTH;
    localparam int unsigned CntW     = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    status_t               status_q;
    logic [CntW-1:0]       words_q, words_d;
    logic [CntW-1:0]       n_q, n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    logic                  accept;
    logic                  pack_en;
    logic                  pack_clear;
    logic                  word_valid;
    logic [31:0]           word;
    logic [ByteCntW-1:0]   byte_cnt;
    logic [7:0]            hdr_lo;
    logic [15:0]           hdr;

    assign accept = rx_valid && status_q.rx_ready;
    assign hdr    = {rx_data, hdr_lo};

    imem_loader_pack u_pack (
        .clk_i        (clock),
        .rst_i        (reset),
        .clear_i      (pack_clear),
        .byte_en_i    (pack_en),
        .byte_i       (rx_data),
        .word_valid_o (word_valid),
        .word_o       (word),
        .byte_cnt_o   (byte_cnt),
        .hdr_lo_o     (hdr_lo)
    );

    // Next-state, counters and pack control for the load sequence.
    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        n_d        = n_q;
        addr_d     = addr_q;
        pack_en    = 1'b0;
        pack_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StHdr;
                    words_d    = '0;
                    pack_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            StHdr: begin
                pack_en = accept;
                if (accept && byte_cnt == HdrLast) begin
                    // Realign the byte counter so data words start at lane 0.
                    pack_clear = 1'b1;
                    if (hdr == 16'd0) begin
                        state_d = StTail;
                    end else if (32'(hdr) > MaxWords) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                        n_d     = CntW'(hdr);
                    end
                end
            end
            StData: begin
                pack_en = accept;
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx_data;
`endif
                    if (byte_cnt == WordLast) begin
                        words_d = words_q + CntW'(1);
                        addr_d  = words_q[ADDR_WIDTH-1:0];
                        if (words_d == n_q) begin
                            state_d = StTail;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCksum: begin
                if (accept) begin
                    state_d = (rx_data == sum_q) ? StDone : StErr;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state with its status flags registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            status_q <= status_of(StIdle);
            words_q  <= '0;
            n_q      <= '0;
            addr_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            status_q <= status_of(state_d);
            words_q  <= words_d;
            n_q      <= n_d;
            addr_q   <= addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign rx_ready     = status_q.rx_ready;
    assign busy         = status_q.busy;
    assign done         = status_q.done;
    assign error        = status_q.error;
    assign core_reset   = status_q.core_reset;
    assign imem_we      = word_valid;
    assign imem_wdata   = word;
    assign imem_addr    = addr_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset behaviour, a two-word load, oversize
// and empty headers, reset mid-load and a single-word load with stream gaps.
module tb_imem_loader;

    localparam int unsigned AW = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Write log captured by the monitor.
    int          cyc = 0;
    int          wr_count = 0;
    logic [31:0] wr_data [64];
    logic [AW-1:0] wr_addr [64];
    logic [AW:0] wr_wl [64];
    int          wr_cyc [64];

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (wr_count < 64) begin
                wr_data[wr_count] = imem_wdata;
                wr_addr[wr_count] = imem_addr;
                wr_wl[wr_count]   = words_loaded;
                wr_cyc[wr_count]  = cyc;
            end
            wr_count = wr_count + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles and hold it until it transfers.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        rx_valid = 1'b0;
        step(gap);
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            ok = (rx_ready === 1'b1);
        end
        if (!ok) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL send_byte_timeout: rx_ready=%b after 50 cycles, required 1", rx_ready);
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        step(3);
        vec_cnt++;
        if ({rx_ready, imem_we, busy, done, error, core_reset} !== 6'b000001) begin
            err_cnt++;
            $display("FAIL reset_flags: got %b required 000001",
                     {rx_ready, imem_we, busy, done, error, core_reset});
        end
        vec_cnt++;
        if ({imem_addr, imem_wdata, words_loaded} !== '0) begin
            err_cnt++;
            $display("FAIL reset_data: addr=%h wdata=%h wl=%0d required 0", imem_addr,
                     imem_wdata, words_loaded);
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            vec_cnt++;
            if ({core_reset, rx_ready, imem_we} !== 3'b100) begin
                err_cnt++;
                $display("FAIL idle_cycle%0d: core_reset/rx_ready/imem_we=%b required 100", i,
                         {core_reset, rx_ready, imem_we});
            end
        end
    endtask

    task automatic test_load_two_words;
        logic [7:0] b [10];
        int base;
        b = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        base = wr_count;
        pulse_start;
        vec_cnt++;
        if ({busy, rx_ready, done, error, core_reset} !== 5'b11001) begin
            err_cnt++;
            $display("FAIL load2_hdr_flags: got %b required 11001",
                     {busy, rx_ready, done, error, core_reset});
        end
        for (int i = 0; i < 10; i++) send_byte(b[i], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hE0, 0);
`endif
        step(2);
        vec_cnt++;
        if (wr_count - base !== 2) begin
            err_cnt++;
            $display("FAIL load2_write_count: got %0d required 2", wr_count - base);
        end else begin
            vec_cnt++;
            if ({wr_addr[base], wr_data[base], wr_wl[base]} !== {10'd0, 32'h00100513, 11'd1}) begin
                err_cnt++;
                $display("FAIL load2_word0: addr=%0d data=%h wl=%0d required 0/00100513/1",
                         wr_addr[base], wr_data[base], wr_wl[base]);
            end
            vec_cnt++;
            if ({wr_addr[base+1], wr_data[base+1], wr_wl[base+1]} !==
                {10'd1, 32'h00200593, 11'd2}) begin
                err_cnt++;
                $display("FAIL load2_word1: addr=%0d data=%h wl=%0d required 1/00200593/2",
                         wr_addr[base+1], wr_data[base+1], wr_wl[base+1]);
            end
            vec_cnt++;
            if (wr_cyc[base+1] - wr_cyc[base] !== 4) begin
                err_cnt++;
                $display("FAIL load2_spacing: got %0d cycles required 4",
                         wr_cyc[base+1] - wr_cyc[base]);
            end
        end
        vec_cnt++;
        if ({busy, rx_ready, done, error, core_reset} !== 5'b00100) begin
            err_cnt++;
            $display("FAIL load2_done_flags: got %b required 00100",
                     {busy, rx_ready, done, error, core_reset});
        end
        vec_cnt++;
        if ({words_loaded, imem_addr, imem_wdata} !== {11'd2, 10'd1, 32'h00200593}) begin
            err_cnt++;
            $display("FAIL load2_hold: wl=%0d addr=%0d wdata=%h required 2/1/00200593",
                     words_loaded, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_oversize;
        int base;
        base = wr_count;
        pulse_start;
        vec_cnt++;
        if ({words_loaded, done} !== {11'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL restart_clear: wl=%0d done=%b required 0/0", words_loaded, done);
        end
        send_byte(8'h01, 0);
        step(1);
        pulse_start;  // must be ignored while receiving the header
        send_byte(8'h08, 0);
        step(2);
        vec_cnt++;
        if ({busy, rx_ready, done, error, core_reset} !== 5'b00011) begin
            err_cnt++;
            $display("FAIL n2049_flags: got %b required 00011",
                     {busy, rx_ready, done, error, core_reset});
        end
        // 1025 words is one past capacity.
        pulse_start;
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        step(2);
        vec_cnt++;
        if ({busy, done, error, core_reset} !== 4'b0011) begin
            err_cnt++;
            $display("FAIL n1025_flags: got %b required 0011", {busy, done, error, core_reset});
        end
        vec_cnt++;
        if (wr_count - base !== 0) begin
            err_cnt++;
            $display("FAIL oversize_writes: got %0d required 0", wr_count - base);
        end
        // Exactly capacity is accepted and waits for data.
        pulse_start;
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        step(2);
        vec_cnt++;
        if ({busy, rx_ready, error} !== 3'b110) begin
            err_cnt++;
            $display("FAIL n1024_flags: busy/rx_ready/error=%b required 110",
                     {busy, rx_ready, error});
        end
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_zero_len;
        int base;
        base = wr_count;
        pulse_start;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        step(2);
`ifdef IMEM_LOADER_CHECKSUM_EN
        vec_cnt++;
        if ({busy, rx_ready, done, error, core_reset} !== 5'b11001) begin
            err_cnt++;
            $display("FAIL zero_cksum_wait: got %b required 11001",
                     {busy, rx_ready, done, error, core_reset});
        end
        send_byte(8'h00, 0);
        step(2);
`endif
        vec_cnt++;
        if ({busy, rx_ready, done, error, core_reset} !== 5'b00100) begin
            err_cnt++;
            $display("FAIL zero_done: got %b required 00100",
                     {busy, rx_ready, done, error, core_reset});
        end
        vec_cnt++;
        if ({wr_count - base, 32'(words_loaded)} !== {32'd0, 32'd0}) begin
            err_cnt++;
            $display("FAIL zero_writes: writes=%0d wl=%0d required 0/0", wr_count - base,
                     words_loaded);
        end
    endtask

    task automatic test_reset_abort;
        logic [7:0] b [8];
        int base;
        b = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        base = wr_count;
        pulse_start;
        for (int i = 0; i < 8; i++) send_byte(b[i], 0);
        reset = 1'b1;
        step(1);
        vec_cnt++;
        if ({rx_ready, imem_we, busy, core_reset} !== 4'b0001) begin
            err_cnt++;
            $display("FAIL abort_in_reset: got %b required 0001",
                     {rx_ready, imem_we, busy, core_reset});
        end
        step(1);
        reset = 1'b0;
        step(20);
        vec_cnt++;
        if (wr_count - base !== 1) begin
            err_cnt++;
            $display("FAIL abort_writes: got %0d required 1", wr_count - base);
        end else begin
            vec_cnt++;
            if (wr_data[base] !== 32'h44332211) begin
                err_cnt++;
                $display("FAIL abort_word0: got %h required 44332211", wr_data[base]);
            end
        end
        vec_cnt++;
        if ({busy, rx_ready, done, error, core_reset} !== 5'b00001) begin
            err_cnt++;
            $display("FAIL abort_idle_flags: got %b required 00001",
                     {busy, rx_ready, done, error, core_reset});
        end
        vec_cnt++;
        if ({imem_addr, imem_wdata, words_loaded} !== '0) begin
            err_cnt++;
            $display("FAIL abort_idle_data: addr=%h wdata=%h wl=%0d required 0", imem_addr,
                     imem_wdata, words_loaded);
        end
    endtask

    task automatic test_gaps;
        logic [7:0] b [6];
        logic       good;
        int         base;
        b = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        for (int g = 0; g <= 5; g++) begin
            good = (g % 2 == 0);
            base = wr_count;
            pulse_start;
            for (int i = 0; i < 6; i++) send_byte(b[i], g);
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(good ? 8'h0A : 8'h0B, g);
`else
            good = 1'b1;
`endif
            step(2);
            vec_cnt++;
            if ({busy, rx_ready, done, error, core_reset} !== {2'b00, good, !good, !good}) begin
                err_cnt++;
                $display("FAIL gap%0d_flags: got %b required %b", g,
                         {busy, rx_ready, done, error, core_reset},
                         {2'b00, good, !good, !good});
            end
            vec_cnt++;
            if (wr_count - base !== 1) begin
                err_cnt++;
                $display("FAIL gap%0d_writes: got %0d required 1", g, wr_count - base);
            end else begin
                vec_cnt++;
                if ({wr_addr[base], wr_data[base], words_loaded} !==
                    {10'd0, 32'h04030201, 11'd1}) begin
                    err_cnt++;
                    $display("FAIL gap%0d_word: addr=%0d data=%h wl=%0d required 0/04030201/1",
                             g, wr_addr[base], wr_data[base], words_loaded);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_load_two_words;
        test_oversize;
        test_zero_len;
        test_reset_abort;
        test_gaps;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
